// File: rtl/act_sram_pkg.sv
// Shared types and geometry for the activation SRAM arbiter.
// Word = CH_NUM x ACT_PER_ADDR activations of BW_PER_ACT bits, one mask bit per activation.
package act_sram_pkg;

  localparam int CH_NUM       = 3;
  localparam int ACT_PER_ADDR = 9;
  localparam int BW_PER_ACT   = 10;
  localparam int DEPTH        = 80;
  localparam int ADDR_W       = 7;
  localparam int WORD_W       = CH_NUM * ACT_PER_ADDR * BW_PER_ACT;
  localparam int MASK_W       = CH_NUM * ACT_PER_ADDR;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [MASK_W-1:0] mask_t;

  // Widen a per-activation mask to a per-bit mask (1 = keep old bit).
  function automatic word_t mask_expand(input mask_t m);
    word_t w;
    for (int i = 0; i < MASK_W; i++) begin
      w[i*BW_PER_ACT +: BW_PER_ACT] = {BW_PER_ACT{m[i]}};
    end
    return w;
  endfunction

endpackage

// File: rtl/act_sram_arbiter_if.sv
// Client-side and SRAM-side bus of act_sram_arbiter.
// slave = arbiter view, master = clients plus SRAM macro.
interface act_sram_arbiter_if
  import act_sram_pkg::*;
#(
  parameter int N_RD = 3
);
  localparam int ID_W = (N_RD > 1) ? $clog2(N_RD) : 1;

  logic                     wr_valid;
  logic                     wr_ready;
  addr_t                    wr_addr;
  mask_t                    wr_mask;
  word_t                    wr_data;
  logic [N_RD-1:0]          rd_valid;
  logic [N_RD-1:0]          rd_ready;
  logic [N_RD*ADDR_W-1:0]   rd_addr;
  logic                     rsp_valid;
  logic [ID_W-1:0]          rsp_id;
  word_t                    rsp_data;
  logic                     addr_err;
  logic                     sram_csb;
  logic                     sram_wsb;
  mask_t                    sram_wordmask;
  addr_t                    sram_waddr;
  addr_t                    sram_raddr;
  word_t                    sram_wdata;
  word_t                    sram_rdata;

  modport slave (
    input  wr_valid, wr_addr, wr_mask, wr_data, rd_valid, rd_addr, sram_rdata,
    output wr_ready, rd_ready, rsp_valid, rsp_id, rsp_data, addr_err,
           sram_csb, sram_wsb, sram_wordmask, sram_waddr, sram_raddr, sram_wdata
  );

  modport master (
    output wr_valid, wr_addr, wr_mask, wr_data, rd_valid, rd_addr, sram_rdata,
    input  wr_ready, rd_ready, rsp_valid, rsp_id, rsp_data, addr_err,
           sram_csb, sram_wsb, sram_wordmask, sram_waddr, sram_raddr, sram_wdata
  );

endinterface

// File: rtl/act_rr_arb.sv
// Round-robin arbiter: one-hot grant searched from the pointer; pointer moves
// to winner+1 only on cycles where adv is set.
module act_rr_arb #(
  parameter  int N     = 3,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             adv,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W-1:0] ptr_next;
  logic             found;
  int               c;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    c         = 0;
    for (int k = 0; k < N; k++) begin
      c = int'(ptr_reg) + k;
      if (c >= N) c = c - N;
      if (!found && req[c]) begin
        found     = 1'b1;
        grant[c]  = 1'b1;
        grant_idx = IDX_W'(c);
      end
    end
  end

  assign ptr_next = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (adv) begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/act_sram_arbiter.sv
// Shares one 1R1W activation SRAM between a write client and N_RD round-robin readers.
// Define ACT_SRAM_ARB_RAW_FWD_EN to forward same-cycle writes to colliding reads instead of stalling.
module act_sram_arbiter
  import act_sram_pkg::*;
#(
  parameter int N_RD = 3
) (
  input  logic              clk,
  input  logic              rst,
  act_sram_arbiter_if.slave bus
);

  localparam int    ID_W    = (N_RD > 1) ? $clog2(N_RD) : 1;
  localparam addr_t DEPTH_A = ADDR_W'(DEPTH);

  addr_t           cl_addr [N_RD];
  logic [N_RD-1:0] rd_req;
  logic [N_RD-1:0] grant;
  logic [ID_W-1:0] grant_idx;
  addr_t           rd_sel_addr;
  logic            wr_acc, wr_ok, rd_acc, rd_ok, wr_issue, rd_issue;
  word_t           rd_word;

  logic            sram_csb_reg, sram_wsb_reg;
  mask_t           sram_wordmask_reg;
  addr_t           sram_waddr_reg, sram_raddr_reg;
  word_t           sram_wdata_reg;
  logic            a_vld_reg, a_oor_reg, b_vld_reg, b_oor_reg;
  logic [ID_W-1:0] a_id_reg, b_id_reg;
  logic            rsp_valid_reg, addr_err_reg;
  logic [ID_W-1:0] rsp_id_reg;
  word_t           rsp_data_reg;

  // A read colliding with this cycle's write address waits a cycle unless forwarding is built in.
  for (genvar gi = 0; gi < N_RD; gi++) begin : g_client
    assign cl_addr[gi] = bus.rd_addr[gi*ADDR_W +: ADDR_W];
`ifdef ACT_SRAM_ARB_RAW_FWD_EN
    assign rd_req[gi]  = bus.rd_valid[gi] & ~rst;
`else
    assign rd_req[gi]  = bus.rd_valid[gi] & ~rst & ~(bus.wr_valid && (cl_addr[gi] == bus.wr_addr));
`endif
  end

  act_rr_arb #(.N(N_RD)) u_rr_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (rd_req),
    .adv       (rd_acc),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign wr_acc      = bus.wr_valid & ~rst;
  assign wr_ok       = bus.wr_addr < DEPTH_A;
  assign rd_acc      = |grant;
  assign rd_sel_addr = cl_addr[grant_idx];
  assign rd_ok       = rd_sel_addr < DEPTH_A;
  assign wr_issue    = wr_acc & wr_ok;
  assign rd_issue    = rd_acc & rd_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_csb_reg      <= 1'b1;
      sram_wsb_reg      <= 1'b1;
      sram_wordmask_reg <= '1;
      sram_waddr_reg    <= '0;
      sram_raddr_reg    <= '0;
      sram_wdata_reg    <= '0;
      a_vld_reg         <= 1'b0;
      a_oor_reg         <= 1'b0;
      a_id_reg          <= '0;
      addr_err_reg      <= 1'b0;
    end else begin
      sram_csb_reg      <= ~(wr_issue | rd_issue);
      sram_wsb_reg      <= ~wr_issue;
      sram_wordmask_reg <= wr_issue ? bus.wr_mask : '1;
      if (wr_issue) begin
        sram_waddr_reg <= bus.wr_addr;
        sram_wdata_reg <= bus.wr_data;
      end
      if (rd_issue) sram_raddr_reg <= rd_sel_addr;
      a_vld_reg <= rd_acc;
      a_oor_reg <= ~rd_ok;
      a_id_reg  <= grant_idx;
      if ((wr_acc & ~wr_ok) | (rd_acc & ~rd_ok)) addr_err_reg <= 1'b1;
    end
  end

`ifdef ACT_SRAM_ARB_RAW_FWD_EN
  logic  a_fwd_reg, b_fwd_reg;
  word_t b_fwd_data_reg;
  mask_t b_fwd_mask_reg;

  // The SRAM returns pre-write data for a same-cycle hit; merge the registered write copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_fwd_reg      <= 1'b0;
      b_fwd_reg      <= 1'b0;
      b_fwd_data_reg <= '0;
      b_fwd_mask_reg <= '1;
    end else begin
      a_fwd_reg <= rd_acc & wr_acc & (rd_sel_addr == bus.wr_addr);
      b_fwd_reg <= a_fwd_reg;
      if (a_fwd_reg) begin
        b_fwd_data_reg <= sram_wdata_reg;
        b_fwd_mask_reg <= sram_wordmask_reg;
      end
    end
  end

  assign rd_word = b_fwd_reg
      ? ((b_fwd_data_reg & ~mask_expand(b_fwd_mask_reg)) | (bus.sram_rdata & mask_expand(b_fwd_mask_reg)))
      : bus.sram_rdata;
`else
  assign rd_word = bus.sram_rdata;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_vld_reg     <= 1'b0;
      b_oor_reg     <= 1'b0;
      b_id_reg      <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_data_reg  <= '0;
    end else begin
      b_vld_reg     <= a_vld_reg;
      b_oor_reg     <= a_oor_reg;
      b_id_reg      <= a_id_reg;
      rsp_valid_reg <= b_vld_reg;
      if (b_vld_reg) begin
        rsp_id_reg   <= b_id_reg;
        rsp_data_reg <= b_oor_reg ? '0 : rd_word;
      end
    end
  end

  assign bus.wr_ready      = ~rst;
  assign bus.rd_ready      = grant;
  assign bus.rsp_valid     = rsp_valid_reg;
  assign bus.rsp_id        = rsp_id_reg;
  assign bus.rsp_data      = rsp_data_reg;
  assign bus.addr_err      = addr_err_reg;
  assign bus.sram_csb      = sram_csb_reg;
  assign bus.sram_wsb      = sram_wsb_reg;
  assign bus.sram_wordmask = sram_wordmask_reg;
  assign bus.sram_waddr    = sram_waddr_reg;
  assign bus.sram_raddr    = sram_raddr_reg;
  assign bus.sram_wdata    = sram_wdata_reg;

endmodule
